pipe_buf_stage: RTL and testbench

//  Parametrised pipeline buffer stage that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
//  - Holds a DEPTH-entry queue of WIDTH-bit payloads, e.g. WIDTH = $bits(Pipe_Buf_Reg_PKG::id_ex_reg).
//  - Valid/ready handshake on both sides lets hazard logic stall a stage instead of gating clocks.
//  - Synchronous flush squashes wrong-path instructions on a taken branch or jump.
//  - Drives the BUBBLE payload whenever the stage is empty.

---
 rtl/pipe_buf_stage.sv | 109 ++++++++++
 tb/tb_pipe_buf_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_buf_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_buf_stage
// Brief    : Valid/ready pipeline buffer with a DEPTH-entry circular queue,
//            synchronous flush and a BUBBLE payload while empty.
//            Optional occupancy statistics enabled by macro PIPE_BUF_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_buf_stage #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 1,
  parameter int               READY_PASS = 0,
  parameter logic [WIDTH-1:0] BUBBLE     = '0,
  localparam int              CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
`ifdef PIPE_BUF_STAT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
  localparam logic [CW-1:0]      c_depth    = CW'(DEPTH);

  generate
    if (DEPTH < 1 || DEPTH > 8 || WIDTH < 1) begin : g_bad_param
      $error("pipe_buf_stage: DEPTH must be 1..8 and WIDTH >= 1");
    end
  endgenerate

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] ptr);
    return (ptr == c_last_ptr) ? '0 : ptr + c_ptr_w'(1);
  endfunction

  assign w_full    = (r_count == c_depth);
  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : BUBBLE;
  assign count     = r_count;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  generate
    if (READY_PASS != 0) begin : g_ready_pass
      assign in_ready = ~w_full | out_ready;
    end else begin : g_ready_reg
      assign in_ready = ~w_full;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset && !flush && w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

`ifdef PIPE_BUF_STAT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && r_stall_cnt != '1)  r_stall_cnt  <= r_stall_cnt + 32'd1;
      if (!out_valid && out_ready && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_buf_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_buf_stage
// Brief    : Five pipe_buf_stage configurations against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_buf_stage;

  localparam int          N        = 5;
  localparam int          DEP [N]  = '{1, 2, 1, 4, 3};
  localparam int          RPS [N]  = '{0, 0, 1, 0, 1};
  localparam logic [31:0] BUBS [N] = '{32'h0, 32'h0, 32'h0, 32'hA5A5_5A5A, 32'h0000_0013};

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_a     [N];
  logic        in_valid_a  [N];
  logic        out_ready_a [N];
  logic [31:0] in_data_a   [N];
  logic        in_ready_a  [N];
  logic        out_valid_a [N];
  logic [31:0] out_data_a  [N];
  logic [3:0]  count_a     [N];
  logic [0:0]  cnt0;
  logic [1:0]  cnt1;
  logic [0:0]  cnt2;
  logic [2:0]  cnt3;
  logic [1:0]  cnt4;
`ifdef PIPE_BUF_STAT_EN
  logic [31:0] stall_a  [N];
  logic [31:0] bubble_a [N];
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign count_a[0] = {3'b0, cnt0};
  assign count_a[1] = {2'b0, cnt1};
  assign count_a[2] = {3'b0, cnt2};
  assign count_a[3] = {1'b0, cnt3};
  assign count_a[4] = {2'b0, cnt4};

  pipe_buf_stage #(.WIDTH(32), .DEPTH(DEP[0]), .READY_PASS(RPS[0]), .BUBBLE(BUBS[0])) u_d1 (
    .clk(clk), .reset(reset), .flush(flush_a[0]),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_data(in_data_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_data(out_data_a[0]),
    .count(cnt0)
`ifdef PIPE_BUF_STAT_EN
    , .stall_cnt(stall_a[0]), .bubble_cnt(bubble_a[0])
`endif
  );

  pipe_buf_stage #(.WIDTH(32), .DEPTH(DEP[1]), .READY_PASS(RPS[1]), .BUBBLE(BUBS[1])) u_d2 (
    .clk(clk), .reset(reset), .flush(flush_a[1]),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_data(in_data_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_data(out_data_a[1]),
    .count(cnt1)
`ifdef PIPE_BUF_STAT_EN
    , .stall_cnt(stall_a[1]), .bubble_cnt(bubble_a[1])
`endif
  );

  pipe_buf_stage #(.WIDTH(32), .DEPTH(DEP[2]), .READY_PASS(RPS[2]), .BUBBLE(BUBS[2])) u_p1 (
    .clk(clk), .reset(reset), .flush(flush_a[2]),
    .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_data(in_data_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_data(out_data_a[2]),
    .count(cnt2)
`ifdef PIPE_BUF_STAT_EN
    , .stall_cnt(stall_a[2]), .bubble_cnt(bubble_a[2])
`endif
  );

  pipe_buf_stage #(.WIDTH(32), .DEPTH(DEP[3]), .READY_PASS(RPS[3]), .BUBBLE(BUBS[3])) u_d4 (
    .clk(clk), .reset(reset), .flush(flush_a[3]),
    .in_valid(in_valid_a[3]), .in_ready(in_ready_a[3]), .in_data(in_data_a[3]),
    .out_valid(out_valid_a[3]), .out_ready(out_ready_a[3]), .out_data(out_data_a[3]),
    .count(cnt3)
`ifdef PIPE_BUF_STAT_EN
    , .stall_cnt(stall_a[3]), .bubble_cnt(bubble_a[3])
`endif
  );

  pipe_buf_stage #(.WIDTH(32), .DEPTH(DEP[4]), .READY_PASS(RPS[4]), .BUBBLE(BUBS[4])) u_d3 (
    .clk(clk), .reset(reset), .flush(flush_a[4]),
    .in_valid(in_valid_a[4]), .in_ready(in_ready_a[4]), .in_data(in_data_a[4]),
    .out_valid(out_valid_a[4]), .out_ready(out_ready_a[4]), .out_data(out_data_a[4]),
    .count(cnt4)
`ifdef PIPE_BUF_STAT_EN
    , .stall_cnt(stall_a[4]), .bubble_cnt(bubble_a[4])
`endif
  );

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      flush_a[k] = 1'b0; in_valid_a[k] = 1'b1; in_data_a[k] = 32'hDEAD_BEEF; out_ready_a[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_cmp += 4;
      if (out_valid_a[k] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid_a[k]); end
      if (out_data_a[k] !== BUBS[k]) begin n_err++; $display("FAIL reset_out_data[%0d]: got %h expected %h", k, out_data_a[k], BUBS[k]); end
      if (count_a[k] !== 4'd0) begin n_err++; $display("FAIL reset_count[%0d]: got %0d expected 0", k, count_a[k]); end
      if (in_ready_a[k] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, in_ready_a[k]); end
      in_valid_a[k] = 1'b0;
    end
    reset = 1'b1;
  endtask

  task automatic test_latency();
    out_ready_a[0] = 1'b1; in_valid_a[0] = 1'b1; in_data_a[0] = 32'h0000_0013;
    @(negedge clk);
    in_data_a[0] = 32'h0000_0077;
    #1;
    n_cmp += 4;
    if (out_valid_a[0] !== 1'b1) begin n_err++; $display("FAIL lat_valid1: got %b expected 1", out_valid_a[0]); end
    if (out_data_a[0] !== 32'h13) begin n_err++; $display("FAIL lat_data1: got %h expected 00000013", out_data_a[0]); end
    if (count_a[0] !== 4'd1) begin n_err++; $display("FAIL lat_count1: got %0d expected 1", count_a[0]); end
    if (in_ready_a[0] !== 1'b0) begin n_err++; $display("FAIL lat_full_block: got %b expected 0", in_ready_a[0]); end
    @(negedge clk);
    n_cmp += 2;
    if (out_valid_a[0] !== 1'b0) begin n_err++; $display("FAIL lat_valid2: got %b expected 0", out_valid_a[0]); end
    if (out_data_a[0] !== BUBS[0]) begin n_err++; $display("FAIL lat_data2: got %h expected %h", out_data_a[0], BUBS[0]); end
    in_valid_a[0] = 1'b0; out_ready_a[0] = 1'b0;
  endtask

  task automatic test_full_stall();
    out_ready_a[1] = 1'b0; in_valid_a[1] = 1'b1; in_data_a[1] = 32'd1;
    @(negedge clk);
    in_data_a[1] = 32'd2;
    @(negedge clk);
    in_data_a[1] = 32'd3;
    #1;
    n_cmp += 2;
    if (count_a[1] !== 4'd2) begin n_err++; $display("FAIL stall_count: got %0d expected 2", count_a[1]); end
    if (in_ready_a[1] !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b expected 0", in_ready_a[1]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp += 2;
      if (out_data_a[1] !== 32'd1) begin n_err++; $display("FAIL stall_hold[%0d]: got %h expected 00000001", i, out_data_a[1]); end
      if (count_a[1] !== 4'd2) begin n_err++; $display("FAIL stall_hold_count[%0d]: got %0d expected 2", i, count_a[1]); end
    end
    in_valid_a[1] = 1'b0; out_ready_a[1] = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (out_data_a[1] !== 32'd2) begin n_err++; $display("FAIL stall_pop2: got %h expected 00000002", out_data_a[1]); end
    if (count_a[1] !== 4'd1) begin n_err++; $display("FAIL stall_pop_count: got %0d expected 1", count_a[1]); end
    @(negedge clk);
    n_cmp += 2;
    if (out_valid_a[1] !== 1'b0) begin n_err++; $display("FAIL stall_empty: got %b expected 0", out_valid_a[1]); end
    if (count_a[1] !== 4'd0) begin n_err++; $display("FAIL stall_end_count: got %0d expected 0", count_a[1]); end
    out_ready_a[1] = 1'b0;
  endtask

  task automatic test_pass_through();
    out_ready_a[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid_a[2] = 1'b1; in_data_a[2] = 32'h10 + i;
      #1;
      n_cmp++;
      if (in_ready_a[2] !== 1'b1) begin n_err++; $display("FAIL pass_in_ready[%0d]: got %b expected 1", i, in_ready_a[2]); end
      @(negedge clk);
      n_cmp += 2;
      if (out_valid_a[2] !== 1'b1) begin n_err++; $display("FAIL pass_valid[%0d]: got %b expected 1", i, out_valid_a[2]); end
      if (out_data_a[2] !== 32'h10 + i) begin n_err++; $display("FAIL pass_data[%0d]: got %h expected %h", i, out_data_a[2], 32'h10 + i); end
    end
    in_valid_a[2] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid_a[2] !== 1'b0) begin n_err++; $display("FAIL pass_drain: got %b expected 0", out_valid_a[2]); end
    out_ready_a[2] = 1'b0;
  endtask

  task automatic test_flush();
    out_ready_a[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[3] = 1'b1; in_data_a[3] = 32'h31 + i;
      @(negedge clk);
    end
    n_cmp++;
    if (count_a[3] !== 4'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d expected 3", count_a[3]); end
    flush_a[3] = 1'b1; in_data_a[3] = 32'h99;
    #1;
    n_cmp++;
    if (in_ready_a[3] !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b expected 1", in_ready_a[3]); end
    @(negedge clk);
    flush_a[3] = 1'b0; in_valid_a[3] = 1'b0; out_ready_a[3] = 1'b1;
    n_cmp += 3;
    if (count_a[3] !== 4'd0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", count_a[3]); end
    if (out_valid_a[3] !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b expected 0", out_valid_a[3]); end
    if (out_data_a[3] !== BUBS[3]) begin n_err++; $display("FAIL flush_bubble: got %h expected %h", out_data_a[3], BUBS[3]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid_a[3] !== 1'b0 || out_data_a[3] === 32'h99) begin
        n_err++; $display("FAIL flush_squash[%0d]: got valid=%b data=%h expected valid=0 data!=99", i, out_valid_a[3], out_data_a[3]);
      end
    end
    in_valid_a[3] = 1'b1; in_data_a[3] = 32'h55;
    @(negedge clk);
    in_valid_a[3] = 1'b0;
    n_cmp++;
    if (out_data_a[3] !== 32'h55) begin n_err++; $display("FAIL flush_recover: got %h expected 00000055", out_data_a[3]); end
    @(negedge clk);
    out_ready_a[3] = 1'b0;
  endtask

  task automatic test_wrap_stats();
    logic [31:0] q[$];
    int pushed   = 0;
    int m_stall  = 0;
    int m_bubble = 0;
    logic exp_rdy, m_push, m_pop;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < 18; s++) begin
      out_ready_a[4] = (s >= 5);
      in_valid_a[4]  = (pushed < 10);
      in_data_a[4]   = 32'h40 + pushed;
      #1;
      exp_rdy = (q.size() < DEP[4]) || (RPS[4] != 0 && out_ready_a[4]);
      n_cmp += 4;
      if (in_ready_a[4] !== exp_rdy) begin n_err++; $display("FAIL wrap_in_ready[%0d]: got %b expected %b", s, in_ready_a[4], exp_rdy); end
      if (out_valid_a[4] !== (q.size() > 0)) begin n_err++; $display("FAIL wrap_valid[%0d]: got %b expected %b", s, out_valid_a[4], q.size() > 0); end
      if (out_data_a[4] !== ((q.size() > 0) ? q[0] : BUBS[4])) begin
        n_err++; $display("FAIL wrap_data[%0d]: got %h expected %h", s, out_data_a[4], (q.size() > 0) ? q[0] : BUBS[4]);
      end
      if (count_a[4] !== 4'(q.size())) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", s, count_a[4], q.size()); end
      m_push = in_valid_a[4] && exp_rdy;
      m_pop  = (q.size() > 0) && out_ready_a[4];
      if (q.size() > 0 && !out_ready_a[4]) m_stall++;
      if (q.size() == 0 && out_ready_a[4]) m_bubble++;
      @(posedge clk);
      if (m_pop) void'(q.pop_front());
      if (m_push) begin q.push_back(in_data_a[4]); pushed++; end
      @(negedge clk);
    end
`ifdef PIPE_BUF_STAT_EN
    n_cmp += 2;
    if (stall_a[4] !== 32'(m_stall)) begin n_err++; $display("FAIL stall_cnt: got %0d expected %0d", stall_a[4], m_stall); end
    if (bubble_a[4] !== 32'(m_bubble)) begin n_err++; $display("FAIL bubble_cnt: got %0d expected %0d", bubble_a[4], m_bubble); end
`endif
    in_valid_a[4] = 1'b0; out_ready_a[4] = 1'b0;
  endtask

  task automatic test_random(input int k, input int cycles);
    logic [31:0] q[$];
    logic exp_rdy, m_push, m_pop;
    flush_a[k] = 1'b1; in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b0;
    @(negedge clk);
    for (int c = 0; c < cycles; c++) begin
      flush_a[k]     = ($urandom_range(0, 99) < 4);
      in_valid_a[k]  = ($urandom_range(0, 99) < 60);
      out_ready_a[k] = ($urandom_range(0, 99) < 60);
      in_data_a[k]   = $urandom;
      #1;
      exp_rdy = (q.size() < DEP[k]) || (RPS[k] != 0 && out_ready_a[k]);
      n_cmp += 4;
      if (in_ready_a[k] !== exp_rdy) begin n_err++; $display("FAIL rnd_in_ready[%0d/%0d]: got %b expected %b", k, c, in_ready_a[k], exp_rdy); end
      if (out_valid_a[k] !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid[%0d/%0d]: got %b expected %b", k, c, out_valid_a[k], q.size() > 0); end
      if (out_data_a[k] !== ((q.size() > 0) ? q[0] : BUBS[k])) begin
        n_err++; $display("FAIL rnd_data[%0d/%0d]: got %h expected %h", k, c, out_data_a[k], (q.size() > 0) ? q[0] : BUBS[k]);
      end
      if (count_a[k] !== 4'(q.size())) begin n_err++; $display("FAIL rnd_count[%0d/%0d]: got %0d expected %0d", k, c, count_a[k], q.size()); end
      m_push = in_valid_a[k] && exp_rdy;
      m_pop  = (q.size() > 0) && out_ready_a[k];
      @(posedge clk);
      if (flush_a[k]) begin
        q.delete();
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(in_data_a[k]);
      end
      @(negedge clk);
    end
    flush_a[k] = 1'b0; in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_stall();
    test_pass_through();
    test_flush();
    test_wrap_stats();
    for (int k = 0; k < N; k++) test_random(k, 300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
